// File: rtl/cpu_pkg.sv
// Shared types for the nqcpu front end: word addresses, instruction words,
// fetch FSM states and the {instr, pc} entry held in the fetch queue.
// Latency: n/a (types only). Backpressure: n/a.
package cpu_pkg;

   typedef logic [23:0] pc_t;
   typedef logic [15:0] instr_t;

   typedef enum logic {
      FETCH = 1'b0,
      FLUSH = 1'b1
   } fetch_state_t;

   typedef struct packed {
      instr_t instr;
      pc_t    pc;
   } fetch_entry_t;

   // Entries in the fetch queue; also the occupancy at which requests stop.
   localparam logic [1:0] QUEUE_DEPTH = 2'd2;

endpackage

// File: rtl/fetch_queue.sv
// Purpose: 2-entry synchronous FIFO of fetched {instr, pc} entries with clear.
// Latency: a pushed entry is visible at head_dat_o the cycle after the push.
// Backpressure: push into a full queue and pop from an empty queue are ignored.
// Ports: clk/rst_n (sync active-low); push_i/push_dat_i write; pop_i advances
//        head; clear_i empties (wins over push/pop); head_dat_o, count_o.
module fetch_queue
   import cpu_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         clear_i,
   input  fetch_entry_t push_dat_i,
   output fetch_entry_t head_dat_o,
   output logic [1:0]   count_o
);

   fetch_entry_t ent_q [2];
   logic         rd_ptr_q;
   logic         wr_ptr_q;
   logic [1:0]   count_q;
   logic         push_ok;
   logic         pop_ok;

   assign push_ok = push_i && (count_q != QUEUE_DEPTH);
   assign pop_ok  = pop_i && (count_q != 2'd0);

   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr_q <= ~wr_ptr_q;
         if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   // Storage needs no reset: an entry is only observed once count says it is live.
   always_ff @(posedge clk) begin
      if (push_ok) ent_q[wr_ptr_q] <= push_dat_i;
   end

   assign head_dat_o = ent_q[rd_ptr_q];
   assign count_o    = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Purpose: nqcpu fetch front end; issues word reads, queues replies, feeds decode.
// Latency: instruction reaches instr_out one enabled cycle after its handshake.
// Backpressure: en=0 freezes outputs; requests stop once the 2-entry queue would fill.
// Ports: clk, rst_n (sync active-low), en, branch_taken/branch_target from execute;
//        mem_req/mem_addr/mem_ready/mem_rdata read port; instr_out/pc_out/valid_out.
// Optional: define FETCH_STATS_EN to add fetch_count and flush_count outputs.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter pc_t    RESET_PC  = 24'h000000,
   parameter instr_t NOP_INSTR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        branch_taken,
   input  logic [23:0] branch_target,
   output logic        mem_req,
   output logic [23:0] mem_addr,
   input  logic        mem_ready,
   input  logic [15:0] mem_rdata,
   output logic [15:0] instr_out,
   output logic [23:0] pc_out,
   output logic        valid_out
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] flush_count
`endif
);

   fetch_state_t state_q, state_d;
   logic         mem_req_q, mem_req_d;
   pc_t          mem_addr_q, mem_addr_d;
   pc_t          fetch_pc_q, fetch_pc_d;
   instr_t       instr_q, instr_d;
   pc_t          pc_q, pc_d;
   logic         valid_q, valid_d;

   logic         hs;
   logic         q_push, q_pop, q_clear;
   logic [1:0]   q_count;
   logic [1:0]   occ;
   fetch_entry_t q_head;
   fetch_entry_t q_wdat;

   assign hs     = mem_req_q && mem_ready;
   assign q_wdat = '{instr: mem_rdata, pc: mem_addr_q};

   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      fetch_pc_d = fetch_pc_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      valid_d    = valid_q;
      q_push     = 1'b0;
      q_pop      = 1'b0;
      q_clear    = 1'b0;
      occ        = q_count;

      if (branch_taken) begin
         q_clear    = 1'b1;
         valid_d    = 1'b0;
         instr_d    = NOP_INSTR;
         fetch_pc_d = branch_target;
         if (mem_req_q && !mem_ready) begin
            // Stale read still outstanding: keep it stable and drop its reply.
            state_d = FLUSH;
         end else begin
            // Nothing outstanding, or the stale reply lands now (also in FLUSH,
            // where staying would leave no request to wait for).
            state_d    = FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = branch_target;
         end
      end else begin
         // Pop uses the pre-push count, so a word never bypasses the queue.
         q_pop = en && (q_count != 2'd0);
         if (en) begin
            if (q_count != 2'd0) begin
               instr_d = q_head.instr;
               pc_d    = q_head.pc;
               valid_d = 1'b1;
            end else begin
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
            end
         end

         if (state_q == FLUSH) begin
            if (hs) begin
               state_d    = FETCH;
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_pc_q;
            end
         end else begin
            q_push = hs;
            if (hs) fetch_pc_d = mem_addr_q + 24'd1;
            occ = q_count + {1'b0, q_push} - {1'b0, q_pop};
            // A pending request is never withdrawn; decide anew only when idle or done.
            if (hs || !mem_req_q) begin
               mem_req_d  = (occ < QUEUE_DEPTH);
               mem_addr_d = fetch_pc_d;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         mem_req_q  <= 1'b0;
         mem_addr_q <= RESET_PC;
         fetch_pc_q <= RESET_PC;
         instr_q    <= NOP_INSTR;
         pc_q       <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         fetch_pc_q <= fetch_pc_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
      end
   end

   fetch_queue u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (q_push),
      .pop_i      (q_pop),
      .clear_i    (q_clear),
      .push_dat_i (q_wdat),
      .head_dat_o (q_head),
      .count_o    (q_count)
   );

   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign instr_out = instr_q;
   assign pc_out    = pc_q;
   assign valid_out = valid_q;

`ifdef FETCH_STATS_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (q_push)       fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (branch_taken) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign fetch_count = fetch_cnt_q;
   assign flush_count = flush_cnt_q;
`endif

endmodule
